mario_anim_ctrl: RTL

// - Sequences Mario's sprite ROMs: selects the animation frame (stand/walk1-3/jump) and drives the
//   9-bit read_address into the selected 21x21 sprite ROM from the current beam position.
// - Sits between the keyboard/physics logic and the per-frame sprite ROMs + colour mapper.
// - Animation advances only on VSync ticks, so the frame never changes mid-screen.

---
 rtl/mario_sprite_pkg.sv | 45 ++++
 rtl/mario_anim_ctrl_if.sv | 29 ++
 rtl/mario_anim_ctrl_vsync_tick.sv | 31 +++
 rtl/mario_anim_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/mario_sprite_pkg.sv
// Shared types and defaults for the Mario animation controller:
// animation states, frame-select codes and sprite geometry.
package mario_sprite_pkg;

  localparam int SPRITE_W_DEF        = 21;
  localparam int SPRITE_H_DEF        = 21;
  localparam int FRAMES_PER_STEP_DEF = 6;
  localparam int ADDR_W_DEF          = 9;

  // Frame-select codes seen by the ROM mux / colour mapper.
  localparam logic [2:0] FSEL_STAND = 3'd0;
  localparam logic [2:0] FSEL_WALK1 = 3'd1;
  localparam logic [2:0] FSEL_WALK2 = 3'd2;
  localparam logic [2:0] FSEL_WALK3 = 3'd3;
  localparam logic [2:0] FSEL_JUMP  = 3'd4;

  typedef enum logic [2:0] {
    STAND = 3'd0,
    WALK1 = 3'd1,
    WALK2 = 3'd2,
    WALK3 = 3'd3,
    JUMP  = 3'd4
  } anim_state_t;

  // Map an animation state to the frame-select code of its ROM.
  function automatic logic [2:0] frame_code(anim_state_t s);
    case (s)
      WALK1:   return FSEL_WALK1;
      WALK2:   return FSEL_WALK2;
      WALK3:   return FSEL_WALK3;
      JUMP:    return FSEL_JUMP;
      default: return FSEL_STAND;
    endcase
  endfunction

  // Walk cycle successor: WALK1 -> WALK2 -> WALK3 -> WALK1.
  function automatic anim_state_t next_walk(anim_state_t s);
    case (s)
      WALK1:   return WALK2;
      WALK2:   return WALK3;
      default: return WALK1;
    endcase
  endfunction

endpackage

// File: rtl/mario_anim_ctrl_if.sv
// Bus between the game logic (beam position, sprite position, keys,
// physics) and the animation controller (ROM address, frame select).
interface mario_anim_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [9:0]        mario_x;
  logic [9:0]        mario_y;
  logic              move_left;
  logic              move_right;
  logic              airborne;
  logic [ADDR_W-1:0] read_address;
  logic [2:0]        frame_sel;
  logic              facing_left;
  logic              sprite_on;

  // Game-logic side: drives beam/position/keys, consumes sprite outputs.
  modport master (
    output DrawX, DrawY, mario_x, mario_y, move_left, move_right, airborne,
    input  read_address, frame_sel, facing_left, sprite_on
  );

  // Controller side.
  modport slave (
    input  DrawX, DrawY, mario_x, mario_y, move_left, move_right, airborne,
    output read_address, frame_sel, facing_left, sprite_on
  );
endinterface

// File: rtl/mario_anim_ctrl_vsync_tick.sv
// Brings the VSync (frame_clk) into the Clk domain and emits a one-Clk
// pulse on each synchronised rising edge.
module vsync_tick (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q, sync2_q, prev_q;

  // Two-flop synchroniser plus edge history.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: all three flops reset to 1 so a VSync already high at release
      // cannot look like a rising edge while the synchroniser refills.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value,
      // which is what gives the chain its two-stage delay.
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/mario_anim_ctrl.sv
// Mario animation controller: VSync-paced frame FSM plus a one-Clk
// beam-to-ROM address pipeline.
// Build option MARIO_MIRROR_LEFT_EN: left-facing frames reuse the
// right-facing ROMs by mirroring the column index.
module mario_anim_ctrl
  import mario_sprite_pkg::*;
#(
  parameter int SPRITE_W        = SPRITE_W_DEF,
  parameter int SPRITE_H        = SPRITE_H_DEF,
  parameter int FRAMES_PER_STEP = FRAMES_PER_STEP_DEF,
  parameter int ADDR_W          = ADDR_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  mario_anim_ctrl_if.slave   bus
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic tick;

  vsync_tick u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  anim_state_t       state_q, state_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic              facing_q, facing_d;
  logic [2:0]        frame_sel_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sprite_on_q, sprite_on_d;
  logic              dir;

  logic [10:0] col, row, col_eff;
  logic        in_box;

  assign dir = bus.move_left ^ bus.move_right;

  // State, counter, facing and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= STAND;
      step_cnt_q  <= '0;
      facing_q    <= 1'b0;
      frame_sel_q <= FSEL_STAND;
      addr_q      <= '0;
      sprite_on_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      facing_q    <= facing_d;
      frame_sel_q <= frame_code(state_q);
      addr_q      <= addr_d;
      sprite_on_q <= sprite_on_d;
    end
  end

  // Next-state logic; everything holds unless a VSync tick arrives.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    facing_d   = facing_q;
    if (tick) begin
      if (bus.airborne) begin
        state_d    = JUMP;
        step_cnt_d = '0;
      end else begin
        case (state_q)
          STAND, JUMP: begin
            state_d    = dir ? WALK1 : STAND;
            step_cnt_d = '0;
          end
          default: begin
            if (!dir) begin
              state_d    = STAND;
              step_cnt_d = '0;
            end else if (step_cnt_q == CNT_LAST) begin
              state_d    = next_walk(state_q);
              step_cnt_d = '0;
            end else begin
              step_cnt_d = step_cnt_q + 1'b1;
            end
          end
        endcase
        // Direction only changes on the ground with exactly one key held.
        if (dir) facing_d = bus.move_left;
      end
    end
  end

  // Beam-relative sprite coordinates; 11-bit so negatives never alias.
  always_comb begin
    col    = {1'b0, bus.DrawX} - {1'b0, bus.mario_x};
    row    = {1'b0, bus.DrawY} - {1'b0, bus.mario_y};
    in_box = !col[10] && (col < 11'(SPRITE_W)) &&
             !row[10] && (row < 11'(SPRITE_H));
`ifdef MARIO_MIRROR_LEFT_EN
    col_eff = facing_q ? (11'(SPRITE_W - 1) - col) : col;
`else
    col_eff = col;
`endif
    sprite_on_d = in_box;
    addr_d      = in_box ? (ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col_eff))
                         : '0;
  end

  assign bus.read_address = addr_q;
  assign bus.frame_sel    = frame_sel_q;
  assign bus.facing_left  = facing_q;
  assign bus.sprite_on    = sprite_on_q;

endmodule
